// File: rtl/tinyqv_mem_arbiter_pkg.sv
// Shared encodings for the tinyqv memory arbiter: controller transfer sizes
// and the arbiter FSM state set.
package tinyqv_mem_pkg;

  localparam logic [1:0] MEM_SZ_B      = 2'd0;
  localparam logic [1:0] MEM_SZ_H      = 2'd1;
  localparam logic [1:0] MEM_SZ_W      = 2'd2;
  localparam logic [1:0] MEM_SZ_STREAM = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    I_REQ,
    I_RUN,
    I_STOP,
    D_REQ,
    D_WAIT,
    D_CONT
  } state_t;

  function automatic logic is_data_req(input logic [1:0] read_n, input logic [1:0] write_n);
    return (read_n != 2'b11) || (write_n != 2'b11);
  endfunction

endpackage

// File: rtl/tinyqv_mem_arbiter_if.sv
// Command/stream bus between the arbiter (master) and the flash/PSRAM
// controller (slave).
interface tinyqv_mem_arbiter_if #(
  parameter int ADDR_BITS = 25
) ();
  logic                 req;
  logic                 ack;
  logic [ADDR_BITS-1:0] addr;
  logic                 wr;
  logic [1:0]           size;
  logic [31:0]          wdata;
  logic                 stall;
  logic                 stop;
  logic [15:0]          rdata;
  logic                 rvalid;
  logic                 wdone;
  logic                 idle;

  modport master (
    output req, addr, wr, size, wdata, stall, stop,
    input  ack, rdata, rvalid, wdone, idle
  );

  modport slave (
    input  req, addr, wr, size, wdata, stall, stop,
    output ack, rdata, rvalid, wdone, idle
  );
endinterface

// File: rtl/tinyqv_rdata_assembler.sv
// Collects one or two 16-bit read beats into a 32-bit zero-extended word;
// the output word only changes when the final beat of a read lands.
module tinyqv_rdata_assembler
  import tinyqv_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic        beat,
  input  logic [1:0]  size,
  input  logic [15:0] rdata,
  output logic [31:0] data,
  output logic        done
);

  logic        count_reg;
  logic [15:0] lo_reg;
  logic [31:0] data_reg;
  logic        done_reg;
  logic [15:0] beat_lo;

  assign beat_lo = (size == MEM_SZ_B) ? {8'h00, rdata[7:0]} : rdata;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count_reg <= 1'b0;
      lo_reg    <= '0;
      data_reg  <= '0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (start) begin
        count_reg <= 1'b0;
      end else if (beat) begin
        if (size == MEM_SZ_W && !count_reg) begin
          lo_reg    <= rdata;
          count_reg <= 1'b1;
        end else if (size == MEM_SZ_W) begin
          data_reg  <= {rdata, lo_reg};
          count_reg <= 1'b0;
          done_reg  <= 1'b1;
        end else begin
          data_reg <= {16'h0000, beat_lo};
          done_reg <= 1'b1;
        end
      end
    end
  end

  assign data = data_reg;
  assign done = done_reg;

endmodule

// File: rtl/tinyqv_mem_arbiter.sv
// Shares one streaming memory controller between instruction fetch and data
// load/store; data accesses preempt a running instruction stream.
module tinyqv_mem_arbiter
  import tinyqv_mem_pkg::*;
#(
  parameter int ADDR_BITS    = 25,
  parameter int CONT_TIMEOUT = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [23:1] instr_addr,
  input  logic        instr_fetch_restart,
  input  logic        instr_fetch_stall,
  output logic        instr_fetch_started,
  output logic        instr_fetch_stopped,
  output logic [15:0] instr_data_in,
  output logic        instr_ready,
  input  logic [27:0] data_addr,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  input  logic [31:0] data_out,
  input  logic        data_continue,
  output logic        data_ready,
  output logic [31:0] data_in,
  tinyqv_mem_arbiter_if.master mem
);

  localparam int TW = $clog2(CONT_TIMEOUT + 1);

  state_t               state_reg, state_next;
  logic [TW-1:0]        timer_reg, timer_next;
  logic [ADDR_BITS-1:0] req_addr_reg;
  logic                 req_wr_reg;
  logic [1:0]           req_size_reg;
  logic [31:0]          req_wdata_reg;
  logic                 req_cont_reg;
  logic                 data_req, latch_req;
  logic                 asm_start, asm_beat, asm_done, access_done;
  logic                 unused_addr;

  assign data_req    = is_data_req(data_read_n, data_write_n);
  assign unused_addr = &{1'b0, data_addr[27:ADDR_BITS]};

  always_comb begin
    state_next          = state_reg;
    timer_next          = timer_reg;
    latch_req           = 1'b0;
    asm_start           = 1'b0;
    asm_beat            = 1'b0;
    access_done         = 1'b0;
    mem.req             = 1'b0;
    mem.addr            = '0;
    mem.wr              = 1'b0;
    mem.size            = MEM_SZ_B;
    mem.wdata           = '0;
    mem.stall           = 1'b0;
    mem.stop            = 1'b0;
    instr_fetch_started = 1'b0;
    instr_fetch_stopped = 1'b0;
    instr_ready         = 1'b0;
    instr_data_in       = '0;
    data_ready          = 1'b0;
    case (state_reg)
      IDLE: begin
        if (data_req) begin
          state_next = D_REQ;
          latch_req  = 1'b1;
        end else if (instr_fetch_restart) begin
          state_next = I_REQ;
        end
      end
      I_REQ: begin
        mem.req  = 1'b1;
        mem.size = MEM_SZ_STREAM;
        mem.addr = ADDR_BITS'({instr_addr, 1'b0});
        if (mem.ack) begin
          instr_fetch_started = 1'b1;
          state_next          = I_RUN;
        end
      end
      I_RUN: begin
        mem.stall = instr_fetch_stall;
        // A beat arriving alongside a preempting request is still delivered.
        if (mem.rvalid) begin
          instr_ready   = 1'b1;
          instr_data_in = mem.rdata;
        end
        if (data_req || instr_fetch_restart) state_next = I_STOP;
      end
      I_STOP: begin
        mem.stop = 1'b1;
        if (mem.idle) begin
          instr_fetch_stopped = 1'b1;
          if (data_req) begin
            state_next = D_REQ;
            latch_req  = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      D_REQ: begin
        mem.req   = 1'b1;
        mem.addr  = req_addr_reg;
        mem.wr    = req_wr_reg;
        mem.size  = req_size_reg;
        mem.wdata = req_wdata_reg;
        if (mem.ack) begin
          asm_start  = 1'b1;
          state_next = D_WAIT;
        end
      end
      D_WAIT: begin
        if (req_wr_reg) begin
          access_done = mem.wdone;
        end else begin
          asm_beat    = mem.rvalid && !asm_done;
          access_done = asm_done;
        end
        if (access_done) begin
          data_ready = 1'b1;
          timer_next = '0;
          state_next = req_cont_reg ? D_CONT : IDLE;
        end
      end
      D_CONT: begin
        if (data_req) begin
          state_next = D_REQ;
          latch_req  = 1'b1;
        end else if (timer_reg >= TW'(CONT_TIMEOUT - 1)) begin
          state_next = IDLE;
        end else if (timer_reg != TW'(CONT_TIMEOUT)) begin
          timer_next = timer_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg     <= IDLE;
      timer_reg     <= '0;
      req_addr_reg  <= '0;
      req_wr_reg    <= 1'b0;
      req_size_reg  <= MEM_SZ_B;
      req_wdata_reg <= '0;
      req_cont_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      timer_reg <= timer_next;
      // Request fields are frozen here so later CPU changes cannot leak in.
      if (latch_req) begin
        req_addr_reg  <= data_addr[ADDR_BITS-1:0];
        req_wr_reg    <= (data_write_n != 2'b11);
        req_size_reg  <= (data_write_n != 2'b11) ? data_write_n : data_read_n;
        req_wdata_reg <= data_out;
        req_cont_reg  <= data_continue;
      end
    end
  end

  tinyqv_rdata_assembler u_rdata (
    .clk   (clk),
    .rstn  (rstn),
    .start (asm_start),
    .beat  (asm_beat),
    .size  (req_size_reg),
    .rdata (mem.rdata),
    .data  (data_in),
    .done  (asm_done)
  );

endmodule

// File: tb/tb_tinyqv_mem_arbiter.sv
// Directed bench for tinyqv_mem_arbiter: the bench plays both the CPU and
// the memory controller cycle by cycle.
module tb_tinyqv_mem_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic [22:0] instr_addr;
  logic        instr_fetch_restart;
  logic        instr_fetch_stall;
  logic        instr_fetch_started;
  logic        instr_fetch_stopped;
  logic [15:0] instr_data_in;
  logic        instr_ready;
  logic [27:0] data_addr;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_continue;
  logic        data_ready;
  logic [31:0] data_in;

  int total = 0;
  int bad = 0;
  int stream_cnt = 0;
  logic mon_on = 1'b0;

  tinyqv_mem_arbiter_if #(.ADDR_BITS(25)) mem_bus ();

  tinyqv_mem_arbiter #(.ADDR_BITS(25), .CONT_TIMEOUT(4)) dut (
    .clk                 (clk),
    .rstn                (rstn),
    .instr_addr          (instr_addr),
    .instr_fetch_restart (instr_fetch_restart),
    .instr_fetch_stall   (instr_fetch_stall),
    .instr_fetch_started (instr_fetch_started),
    .instr_fetch_stopped (instr_fetch_stopped),
    .instr_data_in       (instr_data_in),
    .instr_ready         (instr_ready),
    .data_addr           (data_addr),
    .data_write_n        (data_write_n),
    .data_read_n         (data_read_n),
    .data_out            (data_out),
    .data_continue       (data_continue),
    .data_ready          (data_ready),
    .data_in             (data_in),
    .mem                 (mem_bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mon_on && mem_bus.req && mem_bus.size == 2'd3) stream_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, required finish before 200000");
    $fatal(1, "watchdog");
  end

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    instr_addr = '0; instr_fetch_restart = 0; instr_fetch_stall = 0;
    data_addr = '0; data_write_n = 2'b11; data_read_n = 2'b11;
    data_out = '0; data_continue = 0;
    mem_bus.ack = 0; mem_bus.rdata = '0; mem_bus.rvalid = 0;
    mem_bus.wdone = 0; mem_bus.idle = 1;
    repeat (3) adv();
    settle();
    total++;
    if ({mem_bus.req, mem_bus.stop, mem_bus.stall} !== 3'b000) begin
      bad++; $display("FAIL reset_mem_ctrl: got req/stop/stall=%b required 000", {mem_bus.req, mem_bus.stop, mem_bus.stall});
    end
    total++;
    if ({instr_fetch_started, instr_fetch_stopped, instr_ready, data_ready} !== 4'b0000) begin
      bad++; $display("FAIL reset_pulses: got %b required 0000", {instr_fetch_started, instr_fetch_stopped, instr_ready, data_ready});
    end
    total++;
    if (data_in !== 32'h0 || instr_data_in !== 16'h0) begin
      bad++; $display("FAIL reset_data: got data_in=%h instr_data_in=%h required 0/0", data_in, instr_data_in);
    end
    $display("reset checked");
    adv();
    rstn = 1'b1;
  endtask

  task automatic test_fetch();
    instr_fetch_restart = 1; instr_addr = 23'h000100;
    adv();
    settle();
    total++;
    if (mem_bus.req !== 1'b1 || mem_bus.addr !== 25'h0000200 || mem_bus.size !== 2'd3) begin
      bad++; $display("FAIL fetch_cmd: got req=%b addr=%h size=%0d required 1/0000200/3", mem_bus.req, mem_bus.addr, mem_bus.size);
    end
    mem_bus.ack = 1;
    #1;
    total++;
    if (instr_fetch_started !== 1'b1) begin
      bad++; $display("FAIL fetch_started: got %b required 1", instr_fetch_started);
    end
    adv();
    mem_bus.ack = 0; instr_fetch_restart = 0; mem_bus.idle = 0;
    settle();
    total++;
    if (instr_ready !== 1'b0 || instr_fetch_started !== 1'b0) begin
      bad++; $display("FAIL fetch_quiet: got ready=%b started=%b required 0/0", instr_ready, instr_fetch_started);
    end
    for (int i = 0; i < 4; i++) begin
      adv();
      mem_bus.rvalid = 1; mem_bus.rdata = 16'h1000 + 16'(i);
      settle();
      total++;
      if (instr_ready !== 1'b1 || instr_data_in !== 16'h1000 + 16'(i)) begin
        bad++; $display("FAIL fetch_beat%0d: got ready=%b data=%h required 1/%h", i, instr_ready, instr_data_in, 16'h1000 + 16'(i));
      end
    end
    adv();
    mem_bus.rvalid = 0;
    $display("fetch stream from 0x000200: 4 beats checked");
  endtask

  task automatic test_preempt_word_read();
    data_read_n = 2'b10; data_addr = 28'h1000004;
    settle();
    total++;
    if (mem_bus.stop !== 1'b0) begin
      bad++; $display("FAIL preempt_nostop: got stop=%b required 0", mem_bus.stop);
    end
    adv();
    mem_bus.rvalid = 1; mem_bus.rdata = 16'hDEAD;
    settle();
    total++;
    if (mem_bus.stop !== 1'b1 || instr_ready !== 1'b0 || instr_fetch_stopped !== 1'b0) begin
      bad++; $display("FAIL preempt_stopping: got stop=%b ready=%b stopped=%b required 1/0/0", mem_bus.stop, instr_ready, instr_fetch_stopped);
    end
    adv();
    mem_bus.rvalid = 0; mem_bus.idle = 1;
    settle();
    total++;
    if (instr_fetch_stopped !== 1'b1) begin
      bad++; $display("FAIL preempt_stopped: got %b required 1", instr_fetch_stopped);
    end
    adv();
    data_addr = 28'h0000BAD;
    settle();
    total++;
    if (mem_bus.req !== 1'b1 || mem_bus.addr !== 25'h1000004 || mem_bus.size !== 2'd2 || mem_bus.wr !== 1'b0) begin
      bad++; $display("FAIL word_read_cmd: got req=%b addr=%h size=%0d wr=%b required 1/1000004/2/0", mem_bus.req, mem_bus.addr, mem_bus.size, mem_bus.wr);
    end
    mem_bus.ack = 1;
    adv();
    mem_bus.ack = 0; mem_bus.rvalid = 1; mem_bus.rdata = 16'h5678;
    settle();
    total++;
    if (data_ready !== 1'b0) begin
      bad++; $display("FAIL word_read_early1: got ready=%b required 0", data_ready);
    end
    adv();
    mem_bus.rdata = 16'h1234;
    settle();
    total++;
    if (data_ready !== 1'b0) begin
      bad++; $display("FAIL word_read_early2: got ready=%b required 0", data_ready);
    end
    adv();
    mem_bus.rvalid = 0;
    settle();
    total++;
    if (data_ready !== 1'b1 || data_in !== 32'h12345678) begin
      bad++; $display("FAIL word_read_data: got ready=%b data=%h required 1/12345678", data_ready, data_in);
    end
    adv();
    data_read_n = 2'b11;
    $display("preempting word read @0x1000004 checked");
  endtask

  task automatic test_byte_read_half_write();
    data_read_n = 2'b00; data_addr = 28'h20;
    adv();
    settle();
    total++;
    if (mem_bus.req !== 1'b1 || mem_bus.size !== 2'd0 || mem_bus.addr !== 25'h20) begin
      bad++; $display("FAIL byte_read_cmd: got req=%b size=%0d addr=%h required 1/0/20", mem_bus.req, mem_bus.size, mem_bus.addr);
    end
    mem_bus.ack = 1;
    adv();
    mem_bus.ack = 0; mem_bus.rvalid = 1; mem_bus.rdata = 16'hABCD;
    adv();
    mem_bus.rvalid = 0;
    settle();
    total++;
    if (data_ready !== 1'b1 || data_in !== 32'h000000CD) begin
      bad++; $display("FAIL byte_read_data: got ready=%b data=%h required 1/000000cd", data_ready, data_in);
    end
    adv();
    data_read_n = 2'b11;
    data_write_n = 2'b01; data_out = 32'h0000BEEF; data_addr = 28'h40;
    adv();
    settle();
    total++;
    if (mem_bus.wr !== 1'b1 || mem_bus.size !== 2'd1 || mem_bus.wdata !== 32'h0000BEEF) begin
      bad++; $display("FAIL half_write_cmd: got wr=%b size=%0d wdata=%h required 1/1/0000beef", mem_bus.wr, mem_bus.size, mem_bus.wdata);
    end
    mem_bus.ack = 1;
    adv();
    mem_bus.ack = 0;
    settle();
    total++;
    if (data_ready !== 1'b0 || data_in !== 32'h000000CD) begin
      bad++; $display("FAIL half_write_wait: got ready=%b data_in=%h required 0/000000cd", data_ready, data_in);
    end
    adv();
    mem_bus.wdone = 1;
    settle();
    total++;
    if (data_ready !== 1'b1) begin
      bad++; $display("FAIL half_write_done: got ready=%b required 1", data_ready);
    end
    adv();
    mem_bus.wdone = 0; data_write_n = 2'b11;
    $display("byte read and half write checked");
  endtask

  task automatic test_continue();
    mon_on = 1;
    data_write_n = 2'b10; data_continue = 1; data_addr = 28'h10; data_out = 32'h11111111;
    adv();
    settle();
    total++;
    if (mem_bus.req !== 1'b1 || mem_bus.addr !== 25'h10 || mem_bus.size !== 2'd2) begin
      bad++; $display("FAIL cont_cmd1: got req=%b addr=%h size=%0d required 1/10/2", mem_bus.req, mem_bus.addr, mem_bus.size);
    end
    mem_bus.ack = 1;
    adv();
    mem_bus.ack = 0; mem_bus.wdone = 1;
    adv();
    mem_bus.wdone = 0; data_write_n = 2'b11;
    settle();
    total++;
    if (mem_bus.req !== 1'b0) begin
      bad++; $display("FAIL cont_hold: got req=%b required 0", mem_bus.req);
    end
    adv();
    data_write_n = 2'b10; data_addr = 28'h14; data_out = 32'h22222222;
    adv();
    settle();
    total++;
    if (mem_bus.req !== 1'b1 || mem_bus.addr !== 25'h14 || mem_bus.size !== 2'd2 || mem_bus.wdata !== 32'h22222222) begin
      bad++; $display("FAIL cont_cmd2: got req=%b addr=%h size=%0d wdata=%h required 1/14/2/22222222", mem_bus.req, mem_bus.addr, mem_bus.size, mem_bus.wdata);
    end
    mem_bus.ack = 1;
    adv();
    mem_bus.ack = 0; mem_bus.wdone = 1;
    adv();
    mem_bus.wdone = 0; data_write_n = 2'b11; data_continue = 0;
    instr_fetch_restart = 1;
    for (int k = 0; k < 5; k++) begin
      settle();
      total++;
      if (mem_bus.req !== 1'b0) begin
        bad++; $display("FAIL cont_timeout_c%0d: got req=%b required 0", k, mem_bus.req);
      end
      adv();
    end
    total++;
    if (stream_cnt !== 0) begin
      bad++; $display("FAIL cont_no_stream: got %0d stream requests required 0", stream_cnt);
    end
    mon_on = 0;
    settle();
    total++;
    if (mem_bus.req !== 1'b1 || mem_bus.size !== 2'd3) begin
      bad++; $display("FAIL cont_then_fetch: got req=%b size=%0d required 1/3", mem_bus.req, mem_bus.size);
    end
    mem_bus.ack = 1;
    adv();
    mem_bus.ack = 0; instr_fetch_restart = 0;
    adv();
    instr_fetch_restart = 1;
    adv();
    instr_fetch_restart = 0;
    settle();
    total++;
    if (instr_fetch_stopped !== 1'b1) begin
      bad++; $display("FAIL restart_stop: got stopped=%b required 1", instr_fetch_stopped);
    end
    adv();
    $display("continued writes @0x10/0x14 and timeout checked");
  endtask

  task automatic test_back_to_back();
    instr_fetch_restart = 1; data_write_n = 2'b00; data_addr = 28'h33; data_out = 32'h5A;
    adv();
    settle();
    total++;
    if (mem_bus.req !== 1'b1 || mem_bus.wr !== 1'b1 || mem_bus.size !== 2'd0) begin
      bad++; $display("FAIL tie_write_first: got req=%b wr=%b size=%0d required 1/1/0", mem_bus.req, mem_bus.wr, mem_bus.size);
    end
    mem_bus.ack = 1;
    adv();
    mem_bus.ack = 0; mem_bus.wdone = 1;
    adv();
    mem_bus.wdone = 0; data_write_n = 2'b11;
    adv();
    instr_addr = 23'h000123;
    settle();
    total++;
    if (mem_bus.req !== 1'b1 || mem_bus.size !== 2'd3 || mem_bus.addr !== 25'h0000246) begin
      bad++; $display("FAIL tie_fetch_after: got req=%b size=%0d addr=%h required 1/3/0000246", mem_bus.req, mem_bus.size, mem_bus.addr);
    end
    mem_bus.ack = 1;
    adv();
    mem_bus.ack = 0; instr_fetch_restart = 0; instr_fetch_stall = 1; mem_bus.idle = 0;
    settle();
    total++;
    if (mem_bus.stall !== 1'b1 || instr_ready !== 1'b0) begin
      bad++; $display("FAIL stall_pass: got stall=%b ready=%b required 1/0", mem_bus.stall, instr_ready);
    end
    adv();
    instr_fetch_stall = 0; mem_bus.rvalid = 1; mem_bus.rdata = 16'h7777;
    data_read_n = 2'b01; data_addr = 28'h80;
    settle();
    total++;
    if (instr_ready !== 1'b1 || instr_data_in !== 16'h7777 || mem_bus.stall !== 1'b0) begin
      bad++; $display("FAIL beat_with_preempt: got ready=%b data=%h stall=%b required 1/7777/0", instr_ready, instr_data_in, mem_bus.stall);
    end
    adv();
    mem_bus.rvalid = 0;
    adv();
    mem_bus.idle = 1;
    adv();
    settle();
    total++;
    if (mem_bus.req !== 1'b1 || mem_bus.size !== 2'd1 || mem_bus.wr !== 1'b0) begin
      bad++; $display("FAIL half_read_cmd: got req=%b size=%0d wr=%b required 1/1/0", mem_bus.req, mem_bus.size, mem_bus.wr);
    end
    mem_bus.ack = 1;
    adv();
    mem_bus.ack = 0;
    $display("restart+write tie, stall and preempt boundary checked");
  endtask

  task automatic test_reset_mid();
    rstn = 1'b0;
    adv();
    rstn = 1'b1; data_read_n = 2'b11;
    mem_bus.rvalid = 1; mem_bus.rdata = 16'hFFFF;
    settle();
    total++;
    if (mem_bus.req !== 1'b0 || data_ready !== 1'b0 || mem_bus.stop !== 1'b0 || data_in !== 32'h0) begin
      bad++; $display("FAIL reset_mid: got req=%b ready=%b stop=%b data_in=%h required 0/0/0/0", mem_bus.req, data_ready, mem_bus.stop, data_in);
    end
    adv();
    mem_bus.rvalid = 0;
    settle();
    total++;
    if (data_ready !== 1'b0 || data_in !== 32'h0 || instr_ready !== 1'b0) begin
      bad++; $display("FAIL stray_beat: got ready=%b data_in=%h iready=%b required 0/0/0", data_ready, data_in, instr_ready);
    end
    adv();
    $display("reset during D_WAIT checked");
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_preempt_word_read();
    test_byte_read_half_write();
    test_continue();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
